// File: rtl/inst_fetch.sv
// inst_fetch: sequential PC fetch over req/ready, in-order response queue, redirect flush, ECALL halt.
// Define IFETCH_ALIGN_CHECK_EN to trap misaligned redirects into ERR and raise o_fetch_err.
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_inst_valid,
  output logic [31:0] o_inst_data,
  output logic [31:0] o_inst_pc,
  input  logic        i_inst_ready,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_halt,
  output logic        o_fetch_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, HALT, ERR} state_t;
  state_t state_q, state_d;

  logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, last_pc_q, last_pc_d;
  logic [CW-1:0] count_q, count_d, outst_q, outst_d, drop_q, drop_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]   data_mem [FIFO_DEPTH];
  logic [31:0]   pc_mem   [FIFO_DEPTH];

  logic        run, credit, redir, misalign, accept, push, pop;
  logic [31:0] target_pc;

`ifdef IFETCH_ALIGN_CHECK_EN
  assign target_pc = i_redirect_pc;
  assign misalign  = (i_redirect_pc[1:0] != 2'b00);
`else
  assign target_pc = {i_redirect_pc[31:2], i_redirect_pc[1:0] & 2'b00};
  assign misalign  = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = RUN;
      RUN: begin
        if (i_redirect && misalign) state_d = ERR;
        else if (i_halt)            state_d = HALT;
      end
      default: state_d = state_q;
    endcase
  end

  // Credit counts queued plus in-flight words, so every response always has a slot.
  always_comb begin
    run        = (state_q == RUN);
    credit     = (({1'b0, count_q} + {1'b0, outst_q}) < DEPTH_W);
    o_imem_req = run && !i_redirect && !i_halt && credit;
`ifdef IFETCH_ALIGN_CHECK_EN
    o_fetch_err = (state_q == ERR);
`else
    o_fetch_err = 1'b0;
`endif
  end

  assign redir        = i_redirect && run;
  assign accept       = o_imem_req && i_imem_ready;
  assign push         = i_imem_rvalid && (drop_q == '0) && !redir;
  assign pop          = o_inst_valid && i_inst_ready && !redir;
  assign o_imem_addr  = fetch_pc_q;
  assign o_inst_valid = (count_q != '0);
  assign o_inst_data  = o_inst_valid ? data_mem[rd_ptr_q] : NOP;
  assign o_inst_pc    = o_inst_valid ? pc_mem[rd_ptr_q] : last_pc_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    last_pc_d  = o_inst_pc;
    outst_d    = outst_q + CW'(accept) - CW'(i_imem_rvalid);
    if (redir) begin
      // Everything still in flight, minus the word landing now, belongs to the old path.
      fetch_pc_d = target_pc;
      resp_pc_d  = target_pc;
      drop_d     = outst_q - CW'(i_imem_rvalid);
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
      if (i_imem_rvalid && (drop_q != '0)) drop_d = drop_q - CW'(1);
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        wr_ptr_d  = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      last_pc_q  <= RESET_PC;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      last_pc_q  <= last_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= i_imem_rdata;
      pc_mem[wr_ptr_q]   <= resp_pc_q;
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: fixed-latency memory model plus a scoreboard of expected {pc, data} in fetch order.
module tb_inst_fetch;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ready;
  logic        i_imem_rvalid = 1'b0;
  logic [31:0] i_imem_rdata = 32'hDEAD_BEEF;
  logic        o_inst_valid;
  logic [31:0] o_inst_data;
  logic [31:0] o_inst_pc;
  logic        i_inst_ready;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        i_halt;
  logic        o_fetch_err;

  inst_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_ready(i_imem_ready),
    .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .o_inst_valid(o_inst_valid), .o_inst_data(o_inst_data), .o_inst_pc(o_inst_pc),
    .i_inst_ready(i_inst_ready), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .i_halt(i_halt), .o_fetch_err(o_fetch_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;

  pend_t pend_q[$];
  exp_t  exp_q[$];
  exp_t  exp_e;
  int errors = 0, checks = 0;
  int cyc = 0, mem_k = 1, acc_cnt = 0, acc_total = 0, pop_cnt = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd7) ^ 32'hC0DE_0000;
  endfunction

  // Memory acceptance and decoder-side scoreboard, both on pre-edge values.
  always @(posedge i_clk) begin
    if (!i_rst_n) begin
      pend_q.delete();
      exp_q.delete();
    end else begin
      if (i_redirect) begin
        exp_q.delete();
      end else if (o_inst_valid && i_inst_ready) begin
        pop_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got pc=%h data=%h, required no instruction", o_inst_pc, o_inst_data);
        end else begin
          exp_e = exp_q.pop_front();
          if (o_inst_pc !== exp_e.pc || o_inst_data !== exp_e.data) begin
            errors++;
            $display("FAIL sb_inst: got pc=%h data=%h, required pc=%h data=%h",
                     o_inst_pc, o_inst_data, exp_e.pc, exp_e.data);
          end
        end
      end
      if (o_imem_req && i_imem_ready) begin
        pend_q.push_back('{addr: o_imem_addr, due: cyc + mem_k});
        exp_q.push_back('{pc: o_imem_addr, data: mem_word(o_imem_addr)});
        acc_cnt++;
        acc_total++;
      end
    end
    cyc++;
  end

  always @(negedge i_clk) begin
    if (pend_q.size() != 0 && pend_q[0].due == cyc) begin
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = mem_word(pend_q[0].addr);
      void'(pend_q.pop_front());
    end else begin
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = 32'hDEAD_BEEF;
    end
  end

  task automatic tick();
    @(negedge i_clk);
    #1;
  endtask

  task automatic do_reset(input logic mem_rdy);
    tick();
    i_rst_n = 1'b0; i_redirect = 1'b0; i_halt = 1'b0;
    i_imem_ready = mem_rdy; i_inst_ready = 1'b1;
    tick();
    i_rst_n = 1'b1;
    acc_cnt = 0; acc_total = 0; pop_cnt = 0;
  endtask

  task automatic wait_valid(input int limit);
    int n = 0;
    while (!o_inst_valid && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    tick();
    i_rst_n = 1'b0;
    tick();
    checks++; if (o_imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b, required 0", o_imem_req); end
    checks++; if (o_imem_addr !== RPC) begin errors++; $display("FAIL reset_addr: got %h, required %h", o_imem_addr, RPC); end
    checks++; if (o_inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", o_inst_valid); end
    checks++; if (o_inst_data !== NOP) begin errors++; $display("FAIL reset_data: got %h, required %h", o_inst_data, NOP); end
    checks++; if (o_inst_pc !== RPC) begin errors++; $display("FAIL reset_pc: got %h, required %h", o_inst_pc, RPC); end
    checks++; if (o_fetch_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, required 0", o_fetch_err); end
    i_rst_n = 1'b1;
    acc_cnt = 0; acc_total = 0; pop_cnt = 0;
    tick();
    checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== RPC) begin errors++; $display("FAIL first_req: got req=%b addr=%h, required req=1 addr=%h", o_imem_req, o_imem_addr, RPC); end
    tick();
    checks++; if (o_inst_valid !== 1'b0 || o_imem_addr !== RPC + 32'd4) begin errors++; $display("FAIL first_accept: got valid=%b addr=%h, required valid=0 addr=%h", o_inst_valid, o_imem_addr, RPC + 32'd4); end
    tick();
    checks++; if (o_inst_valid !== 1'b1 || o_inst_pc !== RPC || o_inst_data !== mem_word(RPC)) begin errors++; $display("FAIL first_inst: got valid=%b pc=%h data=%h, required valid=1 pc=%h data=%h", o_inst_valid, o_inst_pc, o_inst_data, RPC, mem_word(RPC)); end
  endtask

  task automatic test_back_to_back();
    acc_cnt = 0; pop_cnt = 0;
    repeat (16) tick();
    checks++; if (acc_cnt != 16) begin errors++; $display("FAIL b2b_accepts: got %0d, required 16", acc_cnt); end
    checks++; if (pop_cnt != 16) begin errors++; $display("FAIL b2b_pops: got %0d, required 16", pop_cnt); end
    checks++; if (o_imem_addr !== RPC + 32'(4 * acc_total)) begin errors++; $display("FAIL b2b_addr: got %h, required %h", o_imem_addr, RPC + 32'(4 * acc_total)); end
  endtask

  task automatic test_backpressure();
    i_inst_ready = 1'b0;
    repeat (10) tick();
    checks++; if (o_imem_req !== 1'b0) begin errors++; $display("FAIL bp_req: got %b, required 0", o_imem_req); end
    checks++; if (exp_q.size() != DEPTH) begin errors++; $display("FAIL bp_held: got %0d, required %0d", exp_q.size(), DEPTH); end
    checks++; if (o_inst_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b, required 1", o_inst_valid); end
    i_inst_ready = 1'b1;
    pop_cnt = 0;
    repeat (20) tick();
    checks++; if (pop_cnt != 20) begin errors++; $display("FAIL bp_release_pops: got %0d, required 20", pop_cnt); end
  endtask

  task automatic test_redirect_drop();
    mem_k = 3;
    do_reset(1'b0);
    tick();
    i_imem_ready = 1'b1;
    tick();
    tick();
    i_imem_ready = 1'b0;
    checks++; if (acc_cnt != 2) begin errors++; $display("FAIL rd_outstanding: got %0d, required 2", acc_cnt); end
    i_redirect = 1'b1; i_redirect_pc = 32'h0000_0100; i_imem_ready = 1'b1;
    tick();
    i_redirect = 1'b0;
    #1;
    checks++; if (o_inst_valid !== 1'b0) begin errors++; $display("FAIL rd_flush: got %b, required 0", o_inst_valid); end
    checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0000_0100) begin errors++; $display("FAIL rd_target_req: got req=%b addr=%h, required req=1 addr=00000100", o_imem_req, o_imem_addr); end
    wait_valid(20);
    checks++; if (o_inst_valid !== 1'b1 || o_inst_pc !== 32'h0000_0100 || o_inst_data !== mem_word(32'h0000_0100)) begin errors++; $display("FAIL rd_target_inst: got valid=%b pc=%h data=%h, required valid=1 pc=00000100 data=%h", o_inst_valid, o_inst_pc, o_inst_data, mem_word(32'h0000_0100)); end
    repeat (6) tick();
  endtask

  task automatic test_redirect_rvalid_pop();
    logic [31:0] hp;
    int n = 0;
    mem_k = 1;
    do_reset(1'b1);
    while (!(i_imem_rvalid && o_inst_valid) && n < 20) begin
      tick();
      n++;
    end
    checks++; if (!(i_imem_rvalid && o_inst_valid)) begin errors++; $display("FAIL rvp_setup: got rvalid=%b valid=%b, required both 1", i_imem_rvalid, o_inst_valid); end
    hp = o_inst_pc;
    i_redirect = 1'b1; i_redirect_pc = 32'h0000_0200;
    tick();
    i_redirect = 1'b0;
    #1;
    checks++; if (o_inst_valid !== 1'b0 || o_inst_data !== NOP) begin errors++; $display("FAIL rvp_empty: got valid=%b data=%h, required valid=0 data=%h", o_inst_valid, o_inst_data, NOP); end
    checks++; if (o_inst_pc !== hp) begin errors++; $display("FAIL rvp_last_pc: got %h, required %h", o_inst_pc, hp); end
    tick();
    checks++; if (o_inst_valid !== 1'b0) begin errors++; $display("FAIL rvp_gap: got %b, required 0", o_inst_valid); end
    tick();
    checks++; if (o_inst_valid !== 1'b1 || o_inst_pc !== 32'h0000_0200) begin errors++; $display("FAIL rvp_target: got valid=%b pc=%h, required valid=1 pc=00000200", o_inst_valid, o_inst_pc); end
    repeat (4) tick();
  endtask

  task automatic test_halt();
    int n = 0;
    int req_seen = 0;
    mem_k = 1;
    do_reset(1'b1);
    while (acc_cnt < 3 && n < 20) begin
      tick();
      n++;
    end
    i_halt = 1'b1;
    #1;
    checks++; if (acc_cnt != 3 || o_imem_req !== 1'b0) begin errors++; $display("FAIL halt_enter: got accepts=%0d req=%b, required accepts=3 req=0", acc_cnt, o_imem_req); end
    tick();
    i_halt = 1'b0;
    repeat (12) begin
      tick();
      if (o_imem_req) req_seen++;
    end
    checks++; if (req_seen != 0 || acc_cnt != 3) begin errors++; $display("FAIL halt_no_fetch: got req_cycles=%0d accepts=%0d, required 0 and 3", req_seen, acc_cnt); end
    checks++; if (pop_cnt != 3) begin errors++; $display("FAIL halt_delivered: got %0d, required 3", pop_cnt); end
    checks++; if (o_inst_valid !== 1'b0) begin errors++; $display("FAIL halt_drained: got %b, required 0", o_inst_valid); end
  endtask

  task automatic test_align();
    mem_k = 1;
    do_reset(1'b1);
    repeat (4) tick();
    i_redirect = 1'b1; i_redirect_pc = 32'h0000_0102;
    tick();
    i_redirect = 1'b0;
    #1;
`ifdef IFETCH_ALIGN_CHECK_EN
    begin
      int req_seen = 0;
      checks++; if (o_fetch_err !== 1'b1 || o_imem_req !== 1'b0) begin errors++; $display("FAIL align_err: got err=%b req=%b, required err=1 req=0", o_fetch_err, o_imem_req); end
      repeat (6) begin
        tick();
        if (o_imem_req) req_seen++;
      end
      checks++; if (req_seen != 0 || o_fetch_err !== 1'b1 || o_inst_valid !== 1'b0) begin errors++; $display("FAIL align_stuck: got req_cycles=%0d err=%b valid=%b, required 0 1 0", req_seen, o_fetch_err, o_inst_valid); end
    end
`else
    checks++; if (o_fetch_err !== 1'b0 || o_imem_req !== 1'b1 || o_imem_addr !== 32'h0000_0100) begin errors++; $display("FAIL align_forced: got err=%b req=%b addr=%h, required err=0 req=1 addr=00000100", o_fetch_err, o_imem_req, o_imem_addr); end
    wait_valid(20);
    checks++; if (o_inst_valid !== 1'b1 || o_inst_pc !== 32'h0000_0100) begin errors++; $display("FAIL align_inst: got valid=%b pc=%h, required valid=1 pc=00000100", o_inst_valid, o_inst_pc); end
`endif
  endtask

  initial begin
    i_rst_n = 1'b0; i_imem_ready = 1'b1; i_inst_ready = 1'b1;
    i_redirect = 1'b0; i_redirect_pc = '0; i_halt = 1'b0;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_redirect_drop();
    test_redirect_rvalid_pop();
    test_halt();
    test_align();
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1);
  end
endmodule
